// File: rtl/sseg_capture_pkg.sv
// Shared definitions for the seven-segment capture block: segment glyphs
// (active-low a..g), FSM states and anode helpers.
package sseg_capture_pkg;

  typedef enum logic {
    ST_SYNC    = 1'b0,
    ST_COLLECT = 1'b1
  } cap_state_e;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic an_onehot_low(input logic [3:0] an);
    return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
  endfunction

  function automatic logic [1:0] an_to_idx(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    if (!an[1]) idx = 2'd1;
    if (!an[2]) idx = 2'd2;
    if (!an[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Active-low abcdefg pattern to hex nibble; flags blank and unknown glyphs.
module sseg_decode
  import sseg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       bad
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    bad    = 1'b0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default: begin
        nibble = 4'hF;
        bad    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// Reconstructs the four multiplexed seven-segment digits into one coherent
// frame per full scan, with dwell filtering, frame alignment and staleness.
module sseg_capture
  import sseg_capture_pkg::*;
#(
  parameter int MIN_DWELL = 4,
  parameter int TIMEOUT   = 1048576
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  SSEGS,
  input  logic [3:0]  AN,
  output logic [15:0] VALUE,
  output logic [3:0]  DP,
  output logic [3:0]  BLANK,
  output logic        VALID,
  output logic        ERR,
  output logic        STALE
);

  localparam int CW = $clog2(MIN_DWELL + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] DWELL_MAX = CW'(MIN_DWELL);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

  logic [7:0]      seg_q, seg_d, seg_prev_q, seg_prev_d;
  logic [3:0]      an_q, an_d, an_prev_q, an_prev_d;
  logic [CW-1:0]   dwell_q, dwell_d;
  logic            acc_q, acc_d;
  logic [7:0]      acc_seg_q, acc_seg_d;
  logic [3:0]      acc_an_q, acc_an_d;
  cap_state_e      state_q, state_d;
  logic [3:0]      mask_q, mask_d;
  logic            err_acc_q, err_acc_d;
  logic [3:0][3:0] slot_nib_q, slot_nib_d;
  logic [3:0]      slot_dp_q, slot_dp_d;
  logic [3:0]      slot_blank_q, slot_blank_d;
  logic [15:0]     value_q, value_d;
  logic [3:0]      dp_q, dp_d;
  logic [3:0]      blank_q, blank_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;

  logic [3:0] dec_nib;
  logic       dec_blank;
  logic       dec_bad;
  logic [1:0] acc_idx;
  logic       hold;
  logic       wr;

  sseg_decode u_decode (
    .seg    (acc_seg_q[7:1]),
    .nibble (dec_nib),
    .blank  (dec_blank),
    .bad    (dec_bad)
  );

  // Input sampling and dwell filter: accept fires once per stable digit.
  always_comb begin
    seg_d      = SSEGS;
    an_d       = AN;
    seg_prev_d = seg_q;
    an_prev_d  = an_q;
    acc_seg_d  = seg_q;
    acc_an_d   = an_q;
    hold       = (seg_q == seg_prev_q) && (an_q == an_prev_q) && an_onehot_low(an_q);
    dwell_d    = CW'(1);
    acc_d      = 1'b0;
    if (hold) begin
      dwell_d = (dwell_q < DWELL_MAX) ? dwell_q + 1'b1 : dwell_q;
      acc_d   = (dwell_q == DWELL_MAX - 1'b1);
    end
  end

  // Frame assembly: align on digit 0, publish when all four slots are filled.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    err_acc_d    = err_acc_q;
    slot_nib_d   = slot_nib_q;
    slot_dp_d    = slot_dp_q;
    slot_blank_d = slot_blank_q;
    value_d      = value_q;
    dp_d         = dp_q;
    blank_d      = blank_q;
    err_d        = err_q;
    valid_d      = 1'b0;
    tmo_d        = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    acc_idx      = an_to_idx(acc_an_q);
    wr           = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (acc_q && (acc_an_q == 4'b1110)) begin
          wr        = 1'b1;
          mask_d    = 4'b0001;
          err_acc_d = dec_bad;
          state_d   = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (acc_q) begin
          wr        = 1'b1;
          mask_d    = mask_q | (4'b0001 << acc_idx);
          err_acc_d = err_acc_q | dec_bad;
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (wr) begin
      slot_nib_d[acc_idx]   = dec_nib;
      slot_dp_d[acc_idx]    = ~acc_seg_q[0];
      slot_blank_d[acc_idx] = dec_blank;
    end

    if ((state_q == ST_COLLECT) && wr && (mask_d == 4'hF)) begin
      value_d   = slot_nib_d;
      dp_d      = slot_dp_d;
      blank_d   = slot_blank_d;
      err_d     = err_acc_d;
      valid_d   = 1'b1;
      mask_d    = 4'h0;
      err_acc_d = 1'b0;
      tmo_d     = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      seg_q        <= 8'hFF;
      an_q         <= 4'hF;
      seg_prev_q   <= 8'hFF;
      an_prev_q    <= 4'hF;
      dwell_q      <= '0;
      acc_q        <= 1'b0;
      acc_seg_q    <= 8'hFF;
      acc_an_q     <= 4'hF;
      state_q      <= ST_SYNC;
      mask_q       <= 4'h0;
      err_acc_q    <= 1'b0;
      slot_nib_q   <= '0;
      slot_dp_q    <= 4'h0;
      slot_blank_q <= 4'h0;
      value_q      <= 16'h0;
      dp_q         <= 4'h0;
      blank_q      <= 4'h0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      tmo_q        <= TMO_MAX;
    end else begin
      seg_q        <= seg_d;
      an_q         <= an_d;
      seg_prev_q   <= seg_prev_d;
      an_prev_q    <= an_prev_d;
      dwell_q      <= dwell_d;
      acc_q        <= acc_d;
      acc_seg_q    <= acc_seg_d;
      acc_an_q     <= acc_an_d;
      state_q      <= state_d;
      mask_q       <= mask_d;
      err_acc_q    <= err_acc_d;
      slot_nib_q   <= slot_nib_d;
      slot_dp_q    <= slot_dp_d;
      slot_blank_q <= slot_blank_d;
      value_q      <= value_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign VALUE = value_q;
  assign DP    = dp_q;
  assign BLANK = blank_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign STALE = (tmo_q == TMO_MAX);

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture: a frame-level reference model is compared
// against the DUT on every cycle, plus hand-computed literal expectations.
module tb_sseg_capture;

  localparam int MIN_DWELL = 4;
  localparam int TIMEOUT   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ssegs;
  logic [3:0]  an;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        valid;
  logic        err;
  logic        stale;

  always #5 clk = ~clk;

  sseg_capture #(.MIN_DWELL(MIN_DWELL), .TIMEOUT(TIMEOUT)) dut (
    .CLK   (clk),
    .RESET (rst),
    .SSEGS (ssegs),
    .AN    (an),
    .VALUE (value),
    .DP    (dp),
    .BLANK (blank),
    .VALID (valid),
    .ERR   (err),
    .STALE (stale)
  );

  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;
  int v0;
  bit cmp_en   = 1'b0;

  logic [6:0] seg_tab [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int          ecount    = 0;
  int          run       = 0;
  logic [7:0]  prev_seg  = 8'hFF;
  logic [3:0]  prev_an   = 4'hF;
  bit          synced    = 1'b0;
  logic [3:0]  m_nib [4];
  bit          m_dp [4];
  bit          m_blank [4];
  logic [3:0]  m_mask    = 4'h0;
  bit          m_err     = 1'b0;
  int          due       = -1;
  logic [15:0] p_value;
  logic [3:0]  p_dp, p_blank;
  bit          p_err;
  logic [15:0] exp_value = 16'h0;
  logic [3:0]  exp_dp    = 4'h0;
  logic [3:0]  exp_blank = 4'h0;
  bit          exp_valid = 1'b0;
  bit          exp_err   = 1'b0;
  bit          exp_stale = 1'b1;
  int          stale_cnt = TIMEOUT;

  function automatic void model_accept(input logic [7:0] s, input logic [3:0] a);
    int         idx;
    logic [3:0] nib;
    bit         bd, bl;
    idx = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
    nib = 4'hF; bd = 1'b1; bl = 1'b0;
    if (s[7:1] == 7'h7F) begin
      nib = 4'h0; bd = 1'b0; bl = 1'b1;
    end else begin
      for (int d = 0; d < 16; d++)
        if (seg_tab[d] == s[7:1]) begin nib = 4'(d); bd = 1'b0; end
    end
    if (!synced && idx != 0) return;
    if (!synced) begin
      synced = 1'b1; m_mask = 4'h0; m_err = 1'b0;
    end
    m_nib[idx] = nib; m_dp[idx] = ~s[0]; m_blank[idx] = bl;
    m_mask[idx] = 1'b1;
    m_err = m_err | bd;
    if (m_mask == 4'hF) begin
      for (int i = 0; i < 4; i++) begin
        p_value[i*4 +: 4] = m_nib[i];
        p_dp[i]           = m_dp[i];
        p_blank[i]        = m_blank[i];
      end
      p_err  = m_err;
      due    = ecount + 2;
      m_mask = 4'h0;
      m_err  = 1'b0;
    end
  endfunction

  always @(posedge clk) begin
    ecount++;
    if (rst) begin
      run = 0; prev_seg = 8'hFF; prev_an = 4'hF; synced = 1'b0;
      m_mask = 4'h0; m_err = 1'b0; due = -1;
      exp_value = 16'h0; exp_dp = 4'h0; exp_blank = 4'h0;
      exp_valid = 1'b0; exp_err = 1'b0; stale_cnt = TIMEOUT;
    end else begin
      if (due == ecount) begin
        exp_value = p_value; exp_dp = p_dp; exp_blank = p_blank; exp_err = p_err;
        exp_valid = 1'b1; stale_cnt = 0; due = -1;
      end else begin
        exp_valid = 1'b0;
        if (stale_cnt < TIMEOUT) stale_cnt++;
      end
      if ($countones(~an) == 1)
        run = (ssegs == prev_seg && an == prev_an) ? run + 1 : 1;
      else
        run = 0;
      prev_seg = ssegs; prev_an = an;
      if (run == MIN_DWELL) model_accept(ssegs, an);
    end
    exp_stale = (stale_cnt == TIMEOUT);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      if (valid) vld_cnt++;
      chk("cycle_outputs", {5'b0, value, dp, blank, valid, err, stale},
          {5'b0, exp_value, exp_dp, exp_blank, exp_valid, exp_err, exp_stale});
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] dig(input int d, input bit dp_on);
    return {seg_tab[d], ~dp_on};
  endfunction

  task automatic show(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a; ssegs = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan4(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                       input logic [7:0] s3, input int n);
    show(4'b1110, s0, n);
    show(4'b1101, s1, n);
    show(4'b1011, s2, n);
    show(4'b0111, s3, n);
  endtask

  task automatic pulse_reset();
    an = 4'hF; ssegs = 8'hFF; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
    seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000;
    seg_tab[15] = 7'b0111000;
    rst = 1'b1; an = 4'hF; ssegs = 8'hFF;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    #1;
    chk("reset_value", {16'h0, value}, 32'h0);
    chk("reset_flags", {26'h0, dp, valid, err}, 32'h0);
    chk("reset_blank_stale", {27'h0, blank, stale}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    show(4'hF, 8'hFF, 4);

    // "1234" scanned from the rightmost digit, 8 clocks each
    v0 = vld_cnt;
    scan4(dig(4, 0), dig(3, 0), dig(2, 0), dig(1, 0), 8);
    show(4'hF, 8'hFF, 4); #1;
    chk("t1_valid_count", 32'(vld_cnt - v0), 32'd1);
    chk("t1_value", {16'h0, value}, 32'h1234);
    chk("t1_dp_blank_err_stale", {22'h0, dp, blank, err, stale}, 32'h0);

    // each digit held one clock short of the dwell -> nothing accepted
    v0 = vld_cnt;
    repeat (3) scan4(dig(5, 0), dig(6, 0), dig(7, 0), dig(8, 0), MIN_DWELL - 1);
    show(4'hF, 8'hFF, 6); #1;
    chk("t2_no_valid", 32'(vld_cnt - v0), 32'd0);
    chk("t2_value_held", {16'h0, value}, 32'h1234);

    // exactly MIN_DWELL clocks per digit is enough; dp on digit 3
    v0 = vld_cnt;
    scan4(dig(8, 0), dig(9, 0), dig(10, 0), dig(15, 1), MIN_DWELL);
    show(4'hF, 8'hFF, 4); #1;
    chk("t2b_valid_count", 32'(vld_cnt - v0), 32'd1);
    chk("t2b_value", {16'h0, value}, 32'hFA98);
    chk("t2b_dp", {28'h0, dp}, 32'h8);

    // fresh reset, scan starting at AN=1011: ignored until digit 0
    pulse_reset();
    show(4'hF, 8'hFF, 2);
    v0 = vld_cnt;
    show(4'b1011, dig(7, 0), 8);
    show(4'b0111, dig(7, 0), 8);
    show(4'b1110, dig(12, 0), 8);
    show(4'b1101, dig(13, 0), 8); #1;
    chk("t3_no_early_valid", 32'(vld_cnt - v0), 32'd0);
    show(4'b1011, dig(10, 0), 8);
    show(4'b0111, dig(11, 0), 8);
    show(4'hF, 8'hFF, 4); #1;
    chk("t3_valid_count", 32'(vld_cnt - v0), 32'd1);
    chk("t3_value", {16'h0, value}, 32'hBADC);

    // undecodable glyph with dp lit on digit 2, then a clean frame with a blank
    scan4(dig(5, 0), dig(6, 0), {7'b1111110, 1'b0}, dig(9, 0), 8);
    show(4'hF, 8'hFF, 4); #1;
    chk("t4_value", {16'h0, value}, 32'h9F65);
    chk("t4_err", {31'h0, err}, 32'h1);
    chk("t4_dp", {28'h0, dp}, 32'h4);
    scan4(dig(0, 0), 8'hFF, dig(2, 0), dig(3, 0), 8);
    show(4'hF, 8'hFF, 4); #1;
    chk("t4_clean_err", {31'h0, err}, 32'h0);
    chk("t4_clean_value", {16'h0, value}, 32'h3200);
    chk("t4_clean_blank", {28'h0, blank}, 32'h2);

    // idle long enough to go stale, then recover with a frame
    show(4'hF, 8'hFF, TIMEOUT + 6); #1;
    chk("t5_stale", {31'h0, stale}, 32'h1);
    v0 = vld_cnt;
    scan4(dig(1, 0), dig(2, 0), dig(3, 0), dig(4, 0), 8);
    show(4'hF, 8'hFF, 2); #1;
    chk("t5_valid_count", 32'(vld_cnt - v0), 32'd1);
    chk("t5_stale_cleared", {31'h0, stale}, 32'h0);
    chk("t5_value", {16'h0, value}, 32'h4321);

    // reset after three of four digits discards the partial frame
    v0 = vld_cnt;
    show(4'b1110, dig(6, 0), 8);
    show(4'b1101, dig(7, 0), 8);
    show(4'b1011, dig(8, 0), 8);
    pulse_reset(); #1;
    chk("t6_reset_value", {16'h0, value}, 32'h0);
    chk("t6_reset_stale", {31'h0, stale}, 32'h1);
    show(4'b0111, dig(9, 0), 8);
    show(4'b1101, dig(1, 0), 8);
    show(4'hF, 8'hFF, 4); #1;
    chk("t6_no_valid", 32'(vld_cnt - v0), 32'd0);
    scan4(dig(10, 0), dig(11, 0), dig(12, 0), dig(13, 0), 8);
    show(4'hF, 8'hFF, 4); #1;
    chk("t6_valid_count", 32'(vld_cnt - v0), 32'd1);
    chk("t6_value", {16'h0, value}, 32'hDCBA);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
